ir_xmit: RTL and testbench
==========================

# ir_xmit

NEC-protocol infrared transmitter: the transmit-side counterpart of the board's IR receiver. It serializes a 16-bit {address, command} code into a full 32-bit NEC frame, then emits NEC repeat codes for as long as a hold request stays asserted. Its output either drives an IR LED or loops back into the receiver's synchronized input for self-test. It runs in the 27 MHz system clock domain and is controlled by CPU PIO.

## Interface
- T_LEADER_MARK, 243000: leader mark length in cycles (9 ms).
- T_LEADER_SPACE, 121500: leader space length in cycles (4.5 ms).
- T_BIT_MARK, 15188: mark length in cycles for every bit and for the stop mark (562.5 µs).
- T_SPACE0, 15188: space length in cycles for a logic-0 bit.
- T_SPACE1, 45563: space length in cycles for a logic-1 bit.
- T_REPEAT_SPACE, 60750: repeat-code space length in cycles (2.25 ms).
- T_FRAME, 2916000: frame period in cycles (108 ms). It must exceed the longest possible frame.
- CARRIER_DIV, 711: carrier period in cycles (about 38 kHz).
- CARRIER_ON, 237: carrier active cycles per carrier period.
- clk27  in  1  system clock, 27 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- ir_code_i  in  16  {address[15:8], command[7:0]}; sampled when `send_i` is accepted.
- send_i  in  1  transmit request; level-sampled, accepted only in IDLE.
- hold_i  in  1  repeat request; sampled at the end of each frame period.
- ir_tx_o  out  1  IR line, idle high, active-low mark; registered.
- busy_o  out  1  high from the cycle after acceptance until the return to IDLE.
- done_o  out  1  one-cycle pulse on the return to IDLE.

## Operation
- Reset (asynchronous, immediate, including mid-frame) forces:
  - state = IDLE;
  - `ir_tx_o` = 1, `busy_o` = 0, `done_o` = 0;
  - all counters = 0.
- Frame data is 32 bits, sent LSB first: addr, ~addr, cmd, ~cmd.
- States and transitions:
  - IDLE: on `send_i` = 1, latch the 32-bit frame and go to LEAD_MARK. `send_i` is ignored in every other state.
  - LEAD_MARK (mark, T_LEADER_MARK) → LEAD_SPACE (T_LEADER_SPACE) → BIT_MARK.
  - BIT_MARK (T_BIT_MARK) → BIT_SPACE (T_SPACE1 if the current bit is 1, else T_SPACE0).
  - BIT_SPACE: after bit 31, go to STOP_MARK; otherwise advance the bit index and go to BIT_MARK.
  - STOP_MARK (T_BIT_MARK) → GAP.
  - GAP (space) waits until the frame counter reaches T_FRAME, then samples `hold_i`:
    - `hold_i` = 1: go to REP_MARK;
    - `hold_i` = 0: go to IDLE.
  - REP_MARK (T_LEADER_MARK) → REP_SPACE (T_REPEAT_SPACE) → STOP_MARK.
- Counters:
  - The duration counter is 22 bits and reloads on every state change.
  - The frame counter is 22 bits. It clears on entry to LEAD_MARK and REP_MARK and increments every cycle otherwise.
  - All parameters must be < 2^22.
- The latched code is not updated during repeats.
- A `send_i` that is still high on the cycle after returning to IDLE is accepted immediately; the T_FRAME spacing to the previous frame has already been met.

## Timing
- `send_i` is sampled high in IDLE at edge N:
  - `ir_tx_o` = 0 and `busy_o` = 1 from edge N+1;
  - the leader mark is exactly T_LEADER_MARK cycles low.
- Every mark and space segment is exactly its parameter length in cycles, with no gaps or overlaps between segments.
- Leader mark start to next leader/repeat mark start is exactly T_FRAME cycles.
- `done_o` is high for the single cycle on which the state is IDLE again; `busy_o` is 0 on that same cycle.
- Reset mid-operation drives `ir_tx_o` high asynchronously. No `done_o` is generated.

## Configuration
- Macro: IR_XMIT_CARRIER_EN.
- Defined (carrier on):
  - during marks, a carrier counter counts 0..CARRIER_DIV-1; it clears at the start of each mark and wraps;
  - `ir_tx_o` = 0 while the carrier counter < CARRIER_ON, else 1;
  - spaces stay constantly 1.
- Undefined (baseband):
  - marks are constant 0 (baseband, receiver-loopback format);
  - the carrier counter and CARRIER_DIV/CARRIER_ON logic are absent.

## Test plan
All scenarios use baseband (macro undefined) except scenario 5, and these parameter overrides: LEADER_MARK=64, LEADER_SPACE=32, BIT_MARK=4, SPACE0=4, SPACE1=12, REPEAT_SPACE=16, FRAME=1200, CARRIER_DIV=6, CARRIER_ON=2.

1. `ir_code_i` = 16'h10EF, one-cycle `send_i`, `hold_i` = 0:
   - 64-cycle mark, then 32-cycle space;
   - bit stream 0x10, 0xEF, 0xEF, 0x10, LSB first, with spaces of 4 (bit 0) or 12 (bit 1);
   - 4-cycle stop mark;
   - `done_o` exactly 1200 cycles after the first low cycle.
2. `hold_i` held high for 2 frame periods after scenario 1's send:
   - two repeat codes follow (64 low, 16 high, 4 low), each starting at a multiple of 1200 cycles;
   - then `done_o`.
3. `send_i` pulses mid-frame with a new code:
   - the pulse is ignored;
   - the frame content is unchanged and `busy_o` stays 1.
4. `reset_n` asserted during BIT_MARK:
   - `ir_tx_o` = 1 and `busy_o` = 0 immediately;
   - no `done_o`;
   - after release, a new send produces a correct frame.
5. IR_XMIT_CARRIER_EN defined:
   - the leader mark shows a repeating pattern of 2 cycles low, 4 cycles high, across all 64 cycles;
   - spaces are constantly high.
6. `send_i` held high continuously with `hold_i` = 0:
   - back-to-back full frames exactly 1201 cycles apart (1200-cycle frame plus the IDLE cycle);
   - `done_o` pulses between consecutive frames.

Source files
------------

// File: rtl/ir_xmit.sv
// NEC infrared transmitter: sends a full 32-bit frame, then repeat codes while hold_i stays high.
// Define IR_XMIT_CARRIER_EN to modulate marks with a carrier; the default build is baseband.
module ir_xmit #(
    parameter int unsigned T_LEADER_MARK  = 243000,
    parameter int unsigned T_LEADER_SPACE = 121500,
    parameter int unsigned T_BIT_MARK     = 15188,
    parameter int unsigned T_SPACE0       = 15188,
    parameter int unsigned T_SPACE1       = 45563,
    parameter int unsigned T_REPEAT_SPACE = 60750,
    parameter int unsigned T_FRAME        = 2916000
`ifdef IR_XMIT_CARRIER_EN
    ,
    parameter int unsigned CARRIER_DIV    = 711,
    parameter int unsigned CARRIER_ON     = 237
`endif
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic [15:0] ir_code_i,
    input  logic        send_i,
    input  logic        hold_i,
    output logic        ir_tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned CW = 22;

    // Last count value of each segment; counters start at 0 on state entry
    localparam logic [CW-1:0] END_LM    = CW'(T_LEADER_MARK - 1);
    localparam logic [CW-1:0] END_LS    = CW'(T_LEADER_SPACE - 1);
    localparam logic [CW-1:0] END_BM    = CW'(T_BIT_MARK - 1);
    localparam logic [CW-1:0] END_S0    = CW'(T_SPACE0 - 1);
    localparam logic [CW-1:0] END_S1    = CW'(T_SPACE1 - 1);
    localparam logic [CW-1:0] END_RS    = CW'(T_REPEAT_SPACE - 1);
    localparam logic [CW-1:0] END_FRAME = CW'(T_FRAME - 1);
`ifdef IR_XMIT_CARRIER_EN
    localparam logic [CW-1:0] END_CAR   = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] CAR_ON    = CW'(CARRIER_ON);
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GAP,
        S_REP_MARK,
        S_REP_SPACE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   dur_cnt, dur_nxt;
    logic [CW-1:0]   frame_cnt, frame_nxt;
    logic [4:0]      bit_idx, bit_idx_nxt;
    logic [31:0]     frame_data, frame_data_nxt;
    logic            state_chg;
    logic            mark_nxt;
    logic            tx_nxt;
    logic            busy_nxt;
    logic            done_nxt;
`ifdef IR_XMIT_CARRIER_EN
    logic [CW-1:0]   car_cnt, car_nxt;
`endif

    // State register
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counters and next output values
    always_comb begin
        state_nxt      = state;
        frame_data_nxt = frame_data;
        bit_idx_nxt    = bit_idx;

        case (state)
            S_IDLE: begin
                if (send_i) begin
                    state_nxt      = S_LEAD_MARK;
                    frame_data_nxt = {~ir_code_i[7:0], ir_code_i[7:0],
                                      ~ir_code_i[15:8], ir_code_i[15:8]};
                end
            end
            S_LEAD_MARK:  if (dur_cnt == END_LM) state_nxt = S_LEAD_SPACE;
            S_LEAD_SPACE: if (dur_cnt == END_LS) state_nxt = S_BIT_MARK;
            S_BIT_MARK:   if (dur_cnt == END_BM) state_nxt = S_BIT_SPACE;
            S_BIT_SPACE: begin
                if (dur_cnt == (frame_data[bit_idx] ? END_S1 : END_S0)) begin
                    if (bit_idx == 5'd31) begin
                        state_nxt = S_STOP_MARK;
                    end else begin
                        state_nxt   = S_BIT_MARK;
                        bit_idx_nxt = bit_idx + 5'd1;
                    end
                end
            end
            S_STOP_MARK:  if (dur_cnt == END_BM) state_nxt = S_GAP;
            S_GAP: begin
                if (frame_cnt == END_FRAME) begin
                    state_nxt = hold_i ? S_REP_MARK : S_IDLE;
                end
            end
            S_REP_MARK:   if (dur_cnt == END_LM) state_nxt = S_REP_SPACE;
            S_REP_SPACE:  if (dur_cnt == END_RS) state_nxt = S_STOP_MARK;
            default:      state_nxt = S_IDLE;
        endcase

        if (state_nxt == S_LEAD_MARK) begin
            bit_idx_nxt = 5'd0;
        end

        state_chg = (state_nxt != state);
        dur_nxt   = state_chg ? '0 : dur_cnt + CW'(1);
        frame_nxt = (state_chg && (state_nxt == S_LEAD_MARK || state_nxt == S_REP_MARK))
                    ? '0 : frame_cnt + CW'(1);

        mark_nxt = (state_nxt == S_LEAD_MARK) || (state_nxt == S_BIT_MARK) ||
                   (state_nxt == S_STOP_MARK) || (state_nxt == S_REP_MARK);

`ifdef IR_XMIT_CARRIER_EN
        // Carrier phase restarts on every mark entry
        if (!mark_nxt || state_chg) begin
            car_nxt = '0;
        end else begin
            car_nxt = (car_cnt == END_CAR) ? '0 : car_cnt + CW'(1);
        end
        tx_nxt = !(mark_nxt && (car_nxt < CAR_ON));
`else
        tx_nxt = !mark_nxt;
`endif

        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state != S_IDLE) && (state_nxt == S_IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            dur_cnt    <= '0;
            frame_cnt  <= '0;
            bit_idx    <= '0;
            frame_data <= '0;
            ir_tx_o    <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            dur_cnt    <= dur_nxt;
            frame_cnt  <= frame_nxt;
            bit_idx    <= bit_idx_nxt;
            frame_data <= frame_data_nxt;
            ir_tx_o    <= tx_nxt;
            busy_o     <= busy_nxt;
            done_o     <= done_nxt;
        end
    end

`ifdef IR_XMIT_CARRIER_EN
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            car_cnt <= '0;
        end else begin
            car_cnt <= car_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ir_xmit.sv
// Scoreboard bench for ir_xmit: a waveform model per transaction, compared segment by segment.
// Follows IR_XMIT_CARRIER_EN to expect carrier-modulated or baseband marks.
module tb_ir_xmit;

    localparam int LM = 64;
    localparam int LS = 32;
    localparam int BM = 4;
    localparam int S0 = 4;
    localparam int S1 = 12;
    localparam int RS = 16;
    localparam int FR = 1200;
`ifdef IR_XMIT_CARRIER_EN
    localparam int CD = 6;
    localparam int CO = 2;
`endif

    logic        clk27 = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] ir_code = 16'h0;
    logic        send = 1'b0;
    logic        hold = 1'b0;
    logic        ir_tx;
    logic        busy;
    logic        done;

    ir_xmit #(
        .T_LEADER_MARK (LM),
        .T_LEADER_SPACE(LS),
        .T_BIT_MARK    (BM),
        .T_SPACE0      (S0),
        .T_SPACE1      (S1),
        .T_REPEAT_SPACE(RS),
        .T_FRAME       (FR)
`ifdef IR_XMIT_CARRIER_EN
        ,
        .CARRIER_DIV   (CD),
        .CARRIER_ON    (CO)
`endif
    ) dut (
        .clk27    (clk27),
        .reset_n  (reset_n),
        .ir_code_i(ir_code),
        .send_i   (send),
        .hold_i   (hold),
        .ir_tx_o  (ir_tx),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk27 = ~clk27;

    int cyc = 0;
    always @(posedge clk27) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] code;
        int          reps;
    } txn_t;

    txn_t sb[$];
    int   starts[$];
    bit   mon_en = 1'b1;
    int   total = 0;
    int   bad = 0;

    bit exp_w[$];
    bit act_w[$];
    int exp_len[$];
    bit exp_lvl[$];
    int act_len[$];
    bit act_lvl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One segment of the expected line, cycle by cycle
    function automatic void add_seg(input bit mark, input int len);
        for (int k = 0; k < len; k++) begin
`ifdef IR_XMIT_CARRIER_EN
            exp_w.push_back(mark ? (((k % CD) < CO) ? 1'b0 : 1'b1) : 1'b1);
`else
            exp_w.push_back(mark ? 1'b0 : 1'b1);
`endif
        end
    endfunction

    // Expected line from first busy cycle up to (not including) the done cycle
    function automatic void build_expected(input logic [15:0] code, input int reps);
        logic [31:0] d;
        d = {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
        exp_w.delete();
        add_seg(1'b1, LM);
        add_seg(1'b0, LS);
        for (int i = 0; i < 32; i++) begin
            add_seg(1'b1, BM);
            add_seg(1'b0, d[i] ? S1 : S0);
        end
        add_seg(1'b1, BM);
        add_seg(1'b0, FR - exp_w.size());
        for (int r = 0; r < reps; r++) begin
            add_seg(1'b1, LM);
            add_seg(1'b0, RS);
            add_seg(1'b1, BM);
            add_seg(1'b0, FR * (r + 2) - exp_w.size());
        end
    endfunction

    function automatic void rle_exp();
        exp_len.delete();
        exp_lvl.delete();
        foreach (exp_w[i]) begin
            if (i == 0 || exp_w[i] != exp_w[i-1]) begin
                exp_lvl.push_back(exp_w[i]);
                exp_len.push_back(1);
            end else begin
                exp_len[exp_len.size()-1] = exp_len[exp_len.size()-1] + 1;
            end
        end
    endfunction

    function automatic void rle_act();
        act_len.delete();
        act_lvl.delete();
        foreach (act_w[i]) begin
            if (i == 0 || act_w[i] != act_w[i-1]) begin
                act_lvl.push_back(act_w[i]);
                act_len.push_back(1);
            end else begin
                act_len[act_len.size()-1] = act_len[act_len.size()-1] + 1;
            end
        end
    endfunction

    // Monitor: captures each busy window and checks it against the oldest queued transaction
    initial begin
        bit   prev_busy;
        int   n;
        int   st;
        bit   done_in;
        bit   aborted;
        int   m;
        txn_t t;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk27);
            if (reset_n && mon_en && busy === 1'b1 && !prev_busy) begin
                n = 0;
                st = cyc;
                done_in = 1'b0;
                aborted = 1'b0;
                act_w.delete();
                while (busy === 1'b1 && n < 20000) begin
                    act_w.push_back(ir_tx);
                    if (done === 1'b1) done_in = 1'b1;
                    n++;
                    @(negedge clk27);
                    if (!reset_n || !mon_en) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    check("done_at_end", 32'(done), 32'd1);
                    check("done_inside_busy", 32'(done_in), 32'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        t = sb.pop_front();
                        build_expected(t.code, t.reps);
                        check("busy_length", 32'(n), 32'(exp_w.size()));
                        rle_exp();
                        rle_act();
                        check("segment_count", 32'(act_len.size()), 32'(exp_len.size()));
                        m = (act_len.size() < exp_len.size()) ? act_len.size() : exp_len.size();
                        for (int i = 0; i < m; i++) begin
                            check($sformatf("seg%0d_level", i), 32'(act_lvl[i]), 32'(exp_lvl[i]));
                            check($sformatf("seg%0d_len", i), 32'(act_len[i]), 32'(exp_len[i]));
                        end
                        starts.push_back(st);
                    end
                end
            end
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(posedge clk27);
        #1;
    endtask

    // Issue one send; glitch_at > 0 pulses send with another code mid-frame
    task automatic send_txn(input logic [15:0] code, input int reps, input int glitch_at, input bit scored);
        int t0;
        @(posedge clk27);
        #1;
        ir_code = code;
        hold = (reps > 0);
        send = 1'b1;
        if (scored) sb.push_back('{code, reps});
        @(posedge clk27);
        #1;
        send = 1'b0;
        ir_code = 16'($urandom);
        t0 = cyc;
        if (glitch_at > 0) begin
            wait_until(t0 + glitch_at);
            ir_code = ~code;
            send = 1'b1;
            @(posedge clk27);
            #1;
            check("busy_during_glitch", 32'(busy), 32'd1);
            send = 1'b0;
        end
        if (reps > 0) begin
            wait_until(t0 + reps * FR + 600);
            hold = 1'b0;
        end
        wait_until(t0 + (reps + 1) * FR + 3);
    endtask

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nst;
        bit saw_done;

        // Reset state
        #12;
        check("reset_tx", 32'(ir_tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk27);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk27);

        // Single frame, then two repeats, then an ignored mid-frame send
        send_txn(16'h10EF, 0, 0, 1'b1);
        send_txn(16'h10EF, 2, 0, 1'b1);
        send_txn(16'($urandom), 0, 300, 1'b1);

        // Reset during a bit mark aborts cleanly
        mon_en = 1'b0;
        @(posedge clk27);
        #1;
        ir_code = 16'($urandom);
        send = 1'b1;
        @(posedge clk27);
        #1;
        send = 1'b0;
        t0 = cyc;
        wait_until(t0 + 97);
        check("pre_reset_mark_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_tx", 32'(ir_tx), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk27);
            if (done === 1'b1) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk27);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("no_done_after_reset", 32'(saw_done), 32'd0);
        mon_en = 1'b1;
        send_txn(16'($urandom), 0, 0, 1'b1);

        // send held high: back-to-back frames
        nst = starts.size();
        @(posedge clk27);
        #1;
        ir_code = 16'($urandom);
        hold = 1'b0;
        repeat (3) sb.push_back('{ir_code, 0});
        send = 1'b1;
        @(posedge clk27);
        #1;
        t0 = cyc;
        wait_until(t0 + 2 * (FR + 1) + 600);
        send = 1'b0;
        wait_until(t0 + 3 * (FR + 1) + 3);
        check("held_frames", 32'(starts.size() - nst), 32'd3);
        if (starts.size() - nst == 3) begin
            check("spacing_1", 32'(starts[nst+1] - starts[nst]), 32'(FR + 1));
            check("spacing_2", 32'(starts[nst+2] - starts[nst+1]), 32'(FR + 1));
        end

        // Random codes and repeat counts
        for (int i = 0; i < 4; i++) begin
            send_txn(16'($urandom), int'($urandom_range(0, 1)), 0, 1'b1);
        end

        repeat (10) @(posedge clk27);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
